// File: rtl/s_adder.sv
// Bit-serial LSB-first adder: a two-state Mealy FSM whose single state flop is the carry.
// The sum bit is combinational from the current a, b and the held carry.
module s_adder (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic s
);

    typedef enum logic {
        S0 = 1'b0,
        S1 = 1'b1
    } state_t;

    state_t state_reg;
    logic   carry;

    assign carry = (state_reg == S1);
    assign s     = a ^ b ^ carry;

    // Next carry is the majority of a, b and the current carry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S0;
        end else begin
            case (state_reg)
                S0:      if (a && b)   state_reg <= S1;
                S1:      if (!a && !b) state_reg <= S0;
                default:               state_reg <= S0;
            endcase
        end
    end

endmodule

// File: tb/tb_s_adder.sv
// Directed bench for the bit-serial adder: reset, carry chain, flush, async reset
// and whole-word additions collected from the serial sum stream.
module tb_s_adder;

    logic clk;
    logic reset;
    logic a;
    logic b;
    logic s;

    int n_checks;
    int n_fails;

    s_adder dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .s     (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one bit pair at the falling edge, check s mid-cycle, then the state after the edge.
    task automatic step(input string tag, input logic av, input logic bv,
                        input logic exp_s, input logic exp_state);
        @(negedge clk);
        a = av;
        b = bv;
        #1;
        check({tag, "_s"}, 32'(s), 32'(exp_s));
        @(posedge clk);
        #1;
        check({tag, "_state"}, 32'(dut.state_reg), 32'(exp_state));
        $display("step %s a=%0b b=%0b s=%0b", tag, av, bv, s);
    endtask

    // Serial add of width-bit operands plus one flush cycle; result gathered from s.
    task automatic add_word(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input int width, input logic [8:0] exp);
        logic [8:0] res;
        res = '0;
        for (int i = 0; i <= width; i++) begin
            @(negedge clk);
            a = (i < width) ? av[i] : 1'b0;
            b = (i < width) ? bv[i] : 1'b0;
            #1;
            res[i] = s;
        end
        @(posedge clk);
        #1;
        check(tag, 32'(res), 32'(exp));
        check({tag, "_end_state"}, 32'(dut.state_reg), 32'd0);
        $display("add %s 0x%0h + 0x%0h = 0x%0h", tag, av, bv, res);
    endtask

    typedef struct {
        logic [7:0] av;
        logic [7:0] bv;
        logic [8:0] sum;
    } vec_t;

    vec_t vecs[7];

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;
        a        = 1'b1;
        b        = 1'b1;

        vecs[0] = '{8'hFF, 8'h01, 9'h100};
        vecs[1] = '{8'hAA, 8'h55, 9'h0FF};
        vecs[2] = '{8'h80, 8'h80, 9'h100};
        vecs[3] = '{8'h00, 8'h00, 9'h000};
        vecs[4] = '{8'hFF, 8'hFF, 9'h1FE};
        vecs[5] = '{8'h3C, 8'h0F, 9'h04B};
        vecs[6] = '{8'h7F, 8'h01, 9'h080};

        // Reset held with a=b=1: carry must never be taken.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_s", 32'(s), 32'd0);
            check("rst_state", 32'(dut.state_reg), 32'd0);
        end

        @(negedge clk);
        reset = 1'b1;
        a     = 1'b1;
        b     = 1'b0;
        #1;
        check("post_rst_s", 32'(s), 32'd1);
        @(posedge clk);
        #1;
        check("post_rst_state", 32'(dut.state_reg), 32'd0);

        // Carry chain
        step("cc0", 1'b1, 1'b1, 1'b0, 1'b1);
        step("cc1", 1'b1, 1'b0, 1'b0, 1'b1);
        step("cc2", 1'b0, 1'b1, 1'b0, 1'b1);
        step("cc3", 1'b1, 1'b1, 1'b1, 1'b1);
        step("cc4", 1'b0, 1'b0, 1'b1, 1'b0);

        // 0101 + 0010, no carries
        step("nc0", 1'b1, 1'b0, 1'b1, 1'b0);
        step("nc1", 1'b0, 1'b1, 1'b1, 1'b0);
        step("nc2", 1'b1, 1'b0, 1'b1, 1'b0);
        step("nc3", 1'b0, 1'b0, 1'b0, 1'b0);

        // 1111 + 0001, carry-out flushed on the fifth cycle
        step("of0", 1'b1, 1'b1, 1'b0, 1'b1);
        step("of1", 1'b1, 1'b0, 1'b0, 1'b1);
        step("of2", 1'b1, 1'b0, 1'b0, 1'b1);
        step("of3", 1'b1, 1'b0, 1'b0, 1'b1);
        step("of4", 1'b0, 1'b0, 1'b1, 1'b0);

        // Async reset between edges discards the carry immediately
        step("ar_set", 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        a = 1'b1;
        b = 1'b0;
        #1;
        check("ar_before_s", 32'(s), 32'd0);
        reset = 1'b0;
        #1;
        check("ar_after_s", 32'(s), 32'd1);
        check("ar_after_state", 32'(dut.state_reg), 32'd0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ar_release_state", 32'(dut.state_reg), 32'd0);

        add_word("w4_0101_0010", 8'h05, 8'h02, 4, 9'h007);
        add_word("w4_1111_0001", 8'h0F, 8'h01, 4, 9'h010);

        for (int i = 0; i < 7; i++) begin
            add_word($sformatf("dir%0d", i), vecs[i].av, vecs[i].bv, 8, vecs[i].sum);
        end

        for (int i = 0; i < 100; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            add_word($sformatf("rnd%0d", i), ra, rb, 8, 9'(ra) + 9'(rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
